// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1:N stream demultiplexer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package demux_pkg;

    // Per-beat routing mode, sampled together with each accepted beat.
    localparam logic MODE_UNICAST   = 1'b0;
    localparam logic MODE_BROADCAST = 1'b1;

    // Upper bound on the channel count; the select field never exceeds 6 bits.
    localparam int MAX_CHANNELS = 64;

endpackage : demux_pkg

// File: rtl/demux_channel_reg.sv
// One-entry output register for a single demux channel (valid flag + data).
// Latency: a load at edge t is visible on out_vld/out_dat right after edge t.
// Backpressure: contents hold while out_vld && !out_rdy; free reports room this cycle.
module demux_channel_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_vld,
    input  logic [DATA_WIDTH-1:0] load_dat,
    input  logic                  out_rdy,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_dat,
    output logic                  free
);

    // The slot can take a new beat if empty, or if its current beat leaves this cycle.
    always_comb begin
        free = !out_vld || out_rdy;
    end

    // Load has priority over drain so a same-cycle drain+reload keeps the channel valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (load_vld) begin
            out_vld <= 1'b1;
            out_dat <= load_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule : demux_channel_reg

// File: rtl/demux_1_n_stream.sv
// Registered 1:N stream demux: routes each input beat to one channel or broadcasts to all.
// Latency: 1 cycle from accept to the channel's Valid_Out/Data_Out.
// Backpressure: Ready_Out follows the target channel(s) being free; a stalled channel only blocks beats aimed at it.
module demux_1_n_stream
    import demux_pkg::*;
#(
    parameter  int NUM_CHANNELS = 32,
    parameter  int DATA_WIDTH   = 8,
    parameter  int COUNT_WIDTH  = 16,
    localparam int SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
    input  logic                               Clock_In,
    input  logic                               Reset_In,
    input  logic                               Enable_In,
    input  logic                               Mode_In,
    input  logic [DATA_WIDTH-1:0]              Data_In,
    input  logic [SEL_WIDTH-1:0]               Select_In,
    input  logic                               Valid_In,
    output logic                               Ready_Out,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_Out,
    output logic [NUM_CHANNELS-1:0]            Valid_Out,
    input  logic [NUM_CHANNELS-1:0]            Ready_In,
    output logic [COUNT_WIDTH-1:0]             Drop_Count_Out
);

    // Channel count expressed one bit wider than the select so the range check never truncates.
    localparam logic [SEL_WIDTH:0]     NUM_CH_W  = (SEL_WIDTH + 1)'(NUM_CHANNELS);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [NUM_CHANNELS-1:0] sel_onehot;
    logic [NUM_CHANNELS-1:0] chan_free;
    logic [NUM_CHANNELS-1:0] chan_load_vld;
    logic                    sel_in_range;
    logic                    sel_free;
    logic                    all_free;
    logic                    is_bcast;
    logic                    in_acc_vld;
    logic                    drop_vld;
    logic [COUNT_WIDTH-1:0]  drop_cnt_q;

    // Decode the select into a one-hot; an out-of-range select decodes to all zeros.
    always_comb begin
        sel_onehot = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            sel_onehot[k] = (Select_In == SEL_WIDTH'(k));
        end
        sel_in_range = ({1'b0, Select_In} < NUM_CH_W);
    end

    // Summarise channel availability for the unicast target and for broadcast.
    always_comb begin
        sel_free = |(sel_onehot & chan_free);
        all_free = &chan_free;
        is_bcast = (Mode_In == MODE_BROADCAST);
    end

    // Input ready never looks at Valid_In; out-of-range unicast beats are always taken so they can be discarded.
    always_comb begin
        Ready_Out = 1'b0;
        if (Enable_In) begin
            if (is_bcast) begin
                Ready_Out = all_free;
            end else if (sel_in_range) begin
                Ready_Out = sel_free;
            end else begin
                Ready_Out = 1'b1;
            end
        end
    end

    // Steer an accepted beat into its channel(s), or flag it as dropped when the select is out of range.
    always_comb begin
        in_acc_vld    = Valid_In && Ready_Out;
        chan_load_vld = '0;
        if (in_acc_vld) begin
            chan_load_vld = is_bcast ? {NUM_CHANNELS{1'b1}} : sel_onehot;
        end
        drop_vld = in_acc_vld && !is_bcast && !sel_in_range;
    end

    // One output register per channel, each with its own handshake.
    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
            demux_channel_reg #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_chan (
                .clk      (Clock_In),
                .rst      (Reset_In),
                .load_vld (chan_load_vld[g]),
                .load_dat (Data_In),
                .out_rdy  (Ready_In[g]),
                .out_vld  (Valid_Out[g]),
                .out_dat  (Data_Out[g*DATA_WIDTH +: DATA_WIDTH]),
                .free     (chan_free[g])
            );
        end
    endgenerate

    // Count discarded beats, sticking at all-ones rather than wrapping.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            drop_cnt_q <= '0;
        end else if (drop_vld && (drop_cnt_q != COUNT_MAX)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    // Expose the drop counter.
    always_comb begin
        Drop_Count_Out = drop_cnt_q;
    end

endmodule : demux_1_n_stream

// File: tb/tb_demux_1_n_stream.sv
// Self-checking bench for demux_1_n_stream: a 32-channel instance plus a 5-channel/2-bit-counter instance.
// Latency: expected beats are queued at acceptance and retired when the channel handshakes.
// Backpressure: Ready_In is driven per channel to exercise stalls, drains and reloads.
module tb_demux_1_n_stream;

    typedef struct {
        int         ch;
        logic [7:0] dat;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic         mode;
    logic [7:0]   din;
    logic [4:0]   sel;
    logic         vin;
    logic         rdy_out;
    logic [255:0] dout;
    logic [31:0]  vout;
    logic [31:0]  rin;
    logic [15:0]  drop;

    logic [2:0]   sel2;
    logic         vin2;
    logic         rdy2;
    logic [39:0]  dout2;
    logic [4:0]   vout2;
    logic [4:0]   rin2;
    logic [1:0]   drop2;

    int   total;
    int   bad;
    exp_t exp_q[$];
    int   mon_idx;

    demux_1_n_stream #(
        .NUM_CHANNELS(32),
        .DATA_WIDTH  (8),
        .COUNT_WIDTH (16)
    ) dut (
        .Clock_In      (clk),
        .Reset_In      (rst),
        .Enable_In     (en),
        .Mode_In       (mode),
        .Data_In       (din),
        .Select_In     (sel),
        .Valid_In      (vin),
        .Ready_Out     (rdy_out),
        .Data_Out      (dout),
        .Valid_Out     (vout),
        .Ready_In      (rin),
        .Drop_Count_Out(drop)
    );

    demux_1_n_stream #(
        .NUM_CHANNELS(5),
        .DATA_WIDTH  (8),
        .COUNT_WIDTH (2)
    ) dut5 (
        .Clock_In      (clk),
        .Reset_In      (rst),
        .Enable_In     (en),
        .Mode_In       (mode),
        .Data_In       (din),
        .Select_In     (sel2),
        .Valid_In      (vin2),
        .Ready_Out     (rdy2),
        .Data_Out      (dout2),
        .Valid_Out     (vout2),
        .Ready_In      (rin2),
        .Drop_Count_Out(drop2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one beat into the 32-channel DUT, wait (bounded) for acceptance, queue the expected output.
    task automatic send(input logic m, input logic [4:0] s, input logic [7:0] d);
        bit ok;
        ok   = 1'b0;
        mode = m;
        sel  = s;
        din  = d;
        vin  = 1'b1;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            if (rdy_out) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=no_accept required=accept ch=%0d", s);
        end else if (m) begin
            for (int k = 0; k < 32; k++) exp_q.push_back('{ch: k, dat: d});
        end else begin
            exp_q.push_back('{ch: int'(s), dat: d});
        end
        @(posedge clk);
        #1;
        vin = 1'b0;
    endtask

    // Scoreboard monitor: every completed output handshake retires the oldest queued beat of that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) begin
                if (vout[k] && rin[k]) begin
                    mon_idx = -1;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (mon_idx < 0 && exp_q[j].ch == k) mon_idx = j;
                    end
                    if (mon_idx < 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected ch=%0d actual=%0h required=none", k, dout[k*8 +: 8]);
                    end else begin
                        check($sformatf("sb_ch%0d", k), 64'(dout[k*8 +: 8]), 64'(exp_q[mon_idx].dat));
                        exp_q.delete(mon_idx);
                    end
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b1;
        mode  = 1'b0;
        din   = 8'h00;
        sel   = 5'd0;
        vin   = 1'b0;
        rin   = '1;
        sel2  = 3'd0;
        vin2  = 1'b0;
        rin2  = '1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vout", 64'(vout), 64'h0);
        check("rst_dout_zero", 64'(|dout), 64'h0);
        check("rst_drop", 64'(drop), 64'h0);
        check("rst_ready", 64'(rdy_out), 64'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Unicast A5 to channel 3
        send(1'b0, 5'd3, 8'hA5);
        @(negedge clk);
        check("uni_vout", 64'(vout), 64'h8);
        check("uni_dat3", 64'(dout[31:24]), 64'hA5);
        @(negedge clk);
        check("uni_clear", 64'(vout), 64'h0);

        // Stalled channel 5 blocks only beats aimed at it
        @(posedge clk);
        #1;
        rin[5] = 1'b0;
        send(1'b0, 5'd5, 8'h11);
        mode = 1'b0;
        sel  = 5'd5;
        din  = 8'h22;
        vin  = 1'b1;
        @(negedge clk);
        check("stall_rdy", 64'(rdy_out), 64'h0);
        check("stall_hold", 64'(dout[47:40]), 64'h11);
        @(posedge clk);
        #1;
        sel = 5'd6;
        din = 8'h66;
        @(negedge clk);
        check("other_ch_rdy", 64'(rdy_out), 64'h1);
        exp_q.push_back('{ch: 6, dat: 8'h66});
        @(posedge clk);
        #1;
        vin = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                rin[5] = 1'b1;
            end
            send(1'b0, 5'd5, 8'h22);
        join
        repeat (2) @(negedge clk);
        check("stall_done", 64'(vout), 64'h0);

        // Broadcast blocked by a full, stalled channel 0
        @(posedge clk);
        #1;
        rin[0] = 1'b0;
        send(1'b0, 5'd0, 8'h01);
        mode = 1'b1;
        din  = 8'h3C;
        vin  = 1'b1;
        @(negedge clk);
        check("bcast_blocked", 64'(rdy_out), 64'h0);
        @(posedge clk);
        #1;
        vin = 1'b0;
        fork
            begin
                repeat (2) @(posedge clk);
                #1;
                rin[0] = 1'b1;
            end
            send(1'b1, 5'd0, 8'h3C);
        join
        @(negedge clk);
        check("bcast_vout", 64'(vout), 64'hFFFF_FFFF);
        for (int k = 0; k < 32; k += 7) begin
            check($sformatf("bcast_dat%0d", k), 64'(dout[k*8 +: 8]), 64'h3C);
        end
        @(negedge clk);
        check("bcast_drain", 64'(vout), 64'h0);

        // Out-of-range select on the 5-channel instance: dropped and counted, saturating at 3
        @(posedge clk);
        #1;
        mode = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            sel2 = 3'd6;
            din  = 8'(i);
            vin2 = 1'b1;
            @(negedge clk);
            check($sformatf("drop_rdy%0d", i), 64'(rdy2), 64'h1);
            @(posedge clk);
            #1;
            vin2 = 1'b0;
            @(negedge clk);
            check($sformatf("drop_vout%0d", i), 64'(vout2), 64'h0);
            check($sformatf("drop_cnt%0d", i), 64'(drop2), 64'((i < 3) ? i : 3));
            @(posedge clk);
            #1;
        end

        // Enable low: nothing loads, held channel 7 still drains
        rin[7] = 1'b0;
        send(1'b0, 5'd7, 8'h77);
        en   = 1'b0;
        mode = 1'b0;
        sel  = 5'd8;
        din  = 8'h88;
        vin  = 1'b1;
        @(negedge clk);
        check("en_low_rdy", 64'(rdy_out), 64'h0);
        check("en_low_held", 64'(vout), 64'h80);
        @(posedge clk);
        #1;
        rin[7] = 1'b1;
        @(negedge clk);
        check("en_low_rdy2", 64'(rdy_out), 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("en_low_noload", 64'(vout), 64'h0);
        @(posedge clk);
        #1;
        vin = 1'b0;
        en  = 1'b1;

        // Reset while channels 1 and 2 are full and stalled
        rin[1] = 1'b0;
        rin[2] = 1'b0;
        send(1'b0, 5'd1, 8'hB1);
        send(1'b0, 5'd2, 8'hB2);
        @(negedge clk);
        check("pre_rst_vout", 64'(vout), 64'h6);
        check("pre_rst_drop2", 64'(drop2), 64'h3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_vout", 64'(vout), 64'h0);
        check("mid_rst_dout_zero", 64'(|dout), 64'h0);
        check("mid_rst_drop2", 64'(drop2), 64'h0);
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
            if (exp_q[j].ch == 1 || exp_q[j].ch == 2) exp_q.delete(j);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rin = '1;

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux_1_n_stream
